// File: rtl/mem_stage_cache.sv
// rtl/mem_stage_cache.sv - 2-way set-associative write-through read-allocate MEM-stage data cache
//
// Purpose: sits between the pipeline MEM stage and the SRAM controller. Load hits
// return data combinationally with no stall; load misses fetch a two-word line,
// stores are written through one word at a time. freeze stalls the pipeline
// while an SRAM transaction is outstanding.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   mem_read, mem_write load / store request (store wins if both high)
//   addr, wdata         byte address (ALU result), store data
//   rdata, freeze       load data, pipeline stall
//   sram_rd_en          line read request (line-aligned sram_addr)
//   sram_wr_en          word write request (sram_addr, sram_wdata)
//   sram_rdata          returned line, word 0 in the low half
//   sram_ready          single-cycle completion pulse
module mem_stage_cache #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int SETS      = 64,
   parameter int BASE_ADDR = 1024
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                mem_read,
   input  logic                mem_write,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [DATA_W-1:0]   wdata,
   output logic [DATA_W-1:0]   rdata,
   output logic                freeze,
   output logic                sram_rd_en,
   output logic                sram_wr_en,
   output logic [ADDR_W-1:0]   sram_addr,
   output logic [DATA_W-1:0]   sram_wdata,
   input  logic [2*DATA_W-1:0] sram_rdata,
   input  logic                sram_ready
);

   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = ADDR_W - 3 - IDX_W;

   typedef enum logic [1:0] {S_IDLE, S_RD_MISS, S_WR_THRU} state_t;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_a;
   logic [DATA_W-1:0]   r_wdata;
   logic [DATA_W-1:0]   r_rdata;
   logic [1:0]          r_valid [SETS];
   logic [SETS-1:0]     r_lru;
   logic [TAG_W-1:0]    r_tag   [2][SETS];
   logic [2*DATA_W-1:0] r_line  [2][SETS];

   state_t              w_state_nx;
   logic [ADDR_W-1:0]   w_a;
   logic [IDX_W-1:0]    w_idx;
   logic [TAG_W-1:0]    w_tag;
   logic                w_wsel;
   logic                w_hit0, w_hit1, w_hit, w_hit_way;
   logic [2*DATA_W-1:0] w_hit_line;
   logic                w_victim;
   logic                w_freeze, w_rd_en, w_wr_en;
   logic [ADDR_W-1:0]   w_sram_addr;
   logic [DATA_W-1:0]   w_sram_wdata;
   logic [DATA_W-1:0]   w_rdata;
   logic                w_latch, w_fill, w_word_wr, w_lru_upd, w_lru_nx;

   assign w_a = addr - ADDR_W'(BASE_ADDR);

   // In IDLE the lookup uses the live address; in the busy states it uses the
   // address captured when the request was accepted.
   assign w_idx  = (r_state == S_IDLE) ? w_a[3 +: IDX_W] : r_a[3 +: IDX_W];
   assign w_tag  = (r_state == S_IDLE) ? w_a[ADDR_W-1 -: TAG_W] : r_a[ADDR_W-1 -: TAG_W];
   assign w_wsel = (r_state == S_IDLE) ? w_a[2] : r_a[2];

   assign w_hit0     = r_valid[w_idx][0] && (r_tag[0][w_idx] == w_tag);
   assign w_hit1     = r_valid[w_idx][1] && (r_tag[1][w_idx] == w_tag);
   assign w_hit      = w_hit0 || w_hit1;
   assign w_hit_way  = w_hit1;
   assign w_hit_line = r_line[w_hit_way][w_idx];

   // Fill empty ways first so a cold set never evicts live data.
   assign w_victim = !r_valid[w_idx][0] ? 1'b0 :
                     !r_valid[w_idx][1] ? 1'b1 : r_lru[w_idx];

   always_comb begin
      w_state_nx   = r_state;
      w_freeze     = 1'b0;
      w_rd_en      = 1'b0;
      w_wr_en      = 1'b0;
      w_sram_addr  = '0;
      w_sram_wdata = '0;
      w_rdata      = r_rdata;
      w_latch      = 1'b0;
      w_fill       = 1'b0;
      w_word_wr    = 1'b0;
      w_lru_upd    = 1'b0;
      w_lru_nx     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (mem_write) begin
               w_freeze   = 1'b1;
               w_latch    = 1'b1;
               w_state_nx = S_WR_THRU;
            end else if (mem_read) begin
               if (w_hit) begin
                  w_rdata   = w_wsel ? w_hit_line[DATA_W +: DATA_W] : w_hit_line[DATA_W-1:0];
                  w_lru_upd = 1'b1;
                  w_lru_nx  = ~w_hit_way;
               end else begin
                  w_freeze   = 1'b1;
                  w_latch    = 1'b1;
                  w_state_nx = S_RD_MISS;
               end
            end
         end
         S_RD_MISS: begin
            w_rd_en     = 1'b1;
            w_sram_addr = {r_a[ADDR_W-1:3], 3'b000};
            w_freeze    = !sram_ready;
            if (sram_ready) begin
               w_rdata    = w_wsel ? sram_rdata[DATA_W +: DATA_W] : sram_rdata[DATA_W-1:0];
               w_fill     = 1'b1;
               w_lru_upd  = 1'b1;
               w_lru_nx   = ~w_victim;
               w_state_nx = S_IDLE;
            end
         end
         S_WR_THRU: begin
            w_wr_en      = 1'b1;
            w_sram_addr  = r_a;
            w_sram_wdata = r_wdata;
            w_freeze     = !sram_ready;
            if (sram_ready) begin
               w_state_nx = S_IDLE;
               if (w_hit) begin
                  w_word_wr = 1'b1;
                  w_lru_upd = 1'b1;
                  w_lru_nx  = ~w_hit_way;
               end
            end
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   // Outputs are forced low while reset is held so an abandoned transaction
   // releases the SRAM controller and the pipeline at once.
   assign rdata      = rst ? w_rdata      : '0;
   assign freeze     = rst & w_freeze;
   assign sram_rd_en = rst & w_rd_en;
   assign sram_wr_en = rst & w_wr_en;
   assign sram_addr  = rst ? w_sram_addr  : '0;
   assign sram_wdata = rst ? w_sram_wdata : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_lru   <= '0;
         for (int s = 0; s < SETS; s++) r_valid[s] <= 2'b00;
      end else begin
         r_state <= w_state_nx;
         r_rdata <= w_rdata;
         if (w_latch) begin
            r_a     <= w_a;
            r_wdata <= wdata;
         end
         if (w_lru_upd) r_lru[w_idx] <= w_lru_nx;
         if (w_fill) r_valid[w_idx][w_victim] <= 1'b1;
      end
   end

   // Tag and data arrays carry no reset; the valid bits qualify them.
   always_ff @(posedge clk) begin
      if (rst && w_fill) begin
         r_tag[w_victim][w_idx]  <= w_tag;
         r_line[w_victim][w_idx] <= sram_rdata;
      end
      if (rst && w_word_wr) begin
         if (w_wsel) r_line[w_hit_way][w_idx][DATA_W +: DATA_W] <= r_wdata;
         else        r_line[w_hit_way][w_idx][DATA_W-1:0]       <= r_wdata;
      end
   end

endmodule

// File: tb/tb_mem_stage_cache.sv
// tb/tb_mem_stage_cache.sv - directed self-checking bench for mem_stage_cache
module tb_mem_stage_cache;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        mem_read = 1'b0, mem_write = 1'b0;
   logic [31:0] addr = '0, wdata = '0;
   logic [31:0] rdata;
   logic        freeze, sram_rd_en, sram_wr_en;
   logic [31:0] sram_addr, sram_wdata;
   logic [63:0] sram_rdata = '0;
   logic        sram_ready = 1'b0;

   int checks = 0;
   int failures = 0;

   logic [31:0] mem [logic [31:0]];

   always #5 clk = ~clk;

   mem_stage_cache #(.ADDR_W(32), .DATA_W(32), .SETS(64), .BASE_ADDR(1024)) dut (
      .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
      .addr(addr), .wdata(wdata), .rdata(rdata), .freeze(freeze),
      .sram_rd_en(sram_rd_en), .sram_wr_en(sram_wr_en), .sram_addr(sram_addr),
      .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ready(sram_ready)
   );

   function automatic logic [31:0] word_of(input logic [31:0] o);
      if (mem.exists(o)) return mem[o];
      return o[2] ? (32'h5555_0000 ^ o) : (32'hAAAA_0000 ^ o);
   endfunction

   function automatic logic [63:0] line_of(input logic [31:0] o);
      logic [31:0] b;
      b = {o[31:3], 3'b000};
      return {word_of(b + 32'd4), word_of(b)};
   endfunction

   // Called at posedge+1. SRAM answers after `delay` enable cycles.
   task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input int delay,
                         output int stall, output logic [31:0] data,
                         output bit saw_rd, output bit saw_wr);
      int en_cnt = 0;
      int cyc = 0;
      bit done = 0;
      bit first_en = 1;
      logic [31:0] off, exp_addr;
      off = a - 32'd1024;
      exp_addr = wr ? off : {off[31:3], 3'b000};
      stall = 0; data = '0; saw_rd = 0; saw_wr = 0;
      mem_read = rd; mem_write = wr; addr = a; wdata = wd;
      while (!done && cyc < 60) begin
         sram_ready = 1'b0;
         if (sram_rd_en || sram_wr_en) begin
            en_cnt++;
            if (en_cnt > delay) begin
               sram_ready = 1'b1;
               sram_rdata = line_of(sram_addr);
            end
         end
         @(negedge clk);
         if (sram_rd_en) saw_rd = 1;
         if (sram_wr_en) saw_wr = 1;
         if ((sram_rd_en || sram_wr_en) && first_en) begin
            first_en = 0;
            checks++;
            if (sram_addr !== exp_addr) begin
               failures++;
               $display("FAIL sram_addr a=%h got=%h exp=%h", a, sram_addr, exp_addr);
            end
            if (wr) begin
               checks++;
               if (sram_wdata !== wd) begin
                  failures++;
                  $display("FAIL sram_wdata got=%h exp=%h", sram_wdata, wd);
               end
            end
         end
         if (!freeze) begin
            done = 1;
            data = rdata;
         end else stall++;
         @(posedge clk); #1;
         cyc++;
      end
      mem_read = 0; mem_write = 0; sram_ready = 0;
      if (!done) begin
         checks++; failures++;
         $display("FAIL timeout a=%h got=freeze_stuck exp=release", a);
      end
      if (wr && done) mem[{off[31:2], 2'b00}] = wd;
   endtask

   task automatic expect_read(input string name, input logic [31:0] a, input int delay,
                              input int exp_stall, input logic [31:0] exp_data);
      int st; logic [31:0] d; bit r, w;
      access(1'b1, 1'b0, a, 32'd0, delay, st, d, r, w);
      checks++;
      if (st !== exp_stall) begin
         failures++;
         $display("FAIL %s_stall got=%0d exp=%0d", name, st, exp_stall);
      end
      checks++;
      if (d !== exp_data) begin
         failures++;
         $display("FAIL %s_data got=%h exp=%h", name, d, exp_data);
      end
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({freeze, sram_rd_en, sram_wr_en} !== 3'b000 || rdata !== 32'd0 ||
          sram_addr !== 32'd0 || sram_wdata !== 32'd0) begin
         failures++;
         $display("FAIL reset_outputs got=%b/%h/%h/%h exp=000/0/0/0",
                  {freeze, sram_rd_en, sram_wr_en}, rdata, sram_addr, sram_wdata);
      end
      rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_read_miss_hit;
      expect_read("miss1024", 32'd1024, 4, 5, 32'hAAAA_0000);
      expect_read("hit1028", 32'd1028, 0, 0, 32'h5555_0004);
      @(negedge clk);
      checks++;
      if (rdata !== 32'h5555_0004 || freeze !== 1'b0) begin
         failures++;
         $display("FAIL idle_hold got=%h/%b exp=55550004/0", rdata, freeze);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_lru;
      expect_read("miss1536", 32'd1536, 1, 2, 32'hAAAA_0200);
      expect_read("miss2048", 32'd2048, 0, 1, 32'hAAAA_0400);
      expect_read("hit1536", 32'd1536, 0, 0, 32'hAAAA_0200);
      expect_read("evicted1024", 32'd1024, 0, 1, 32'hAAAA_0000);
   endtask

   task automatic test_write;
      int st; logic [31:0] d; bit r, w;
      access(1'b0, 1'b1, 32'd1028, 32'h1234_5678, 2, st, d, r, w);
      checks++;
      if (st !== 3 || w !== 1'b1 || r !== 1'b0) begin
         failures++;
         $display("FAIL wr_hit_txn got=stall%0d rd%0b wr%0b exp=stall3 rd0 wr1", st, r, w);
      end
      expect_read("after_wr_hit", 32'd1028, 0, 0, 32'h1234_5678);
      access(1'b0, 1'b1, 32'd1060, 32'hCAFE_F00D, 0, st, d, r, w);
      checks++;
      if (st !== 1) begin
         failures++;
         $display("FAIL wr_miss_stall got=%0d exp=1", st);
      end
      expect_read("no_alloc", 32'd1060, 0, 1, 32'hCAFE_F00D);
   endtask

   task automatic test_both_high;
      int st; logic [31:0] d; bit r, w;
      access(1'b1, 1'b1, 32'd1536, 32'h0BAD_BEEF, 1, st, d, r, w);
      checks++;
      if (r !== 1'b0 || w !== 1'b1 || st !== 2) begin
         failures++;
         $display("FAIL both_high got=rd%0b wr%0b stall%0d exp=rd0 wr1 stall2", r, w, st);
      end
      expect_read("both_high_rb", 32'd1536, 0, 0, 32'h0BAD_BEEF);
   endtask

   task automatic test_stray_ready;
      sram_rdata = '1;
      sram_ready = 1'b1;
      @(negedge clk);
      checks++;
      if ({freeze, sram_rd_en, sram_wr_en} !== 3'b000) begin
         failures++;
         $display("FAIL stray_outputs got=%b exp=000", {freeze, sram_rd_en, sram_wr_en});
      end
      @(posedge clk); #1;
      sram_ready = 1'b0;
      expect_read("stray_hit1024", 32'd1024, 0, 0, 32'hAAAA_0000);
   endtask

   task automatic test_reset_mid_miss;
      mem_read = 1'b1; addr = 32'd2048;
      @(negedge clk);
      checks++;
      if (freeze !== 1'b1) begin
         failures++;
         $display("FAIL rst_mid_cycle0 got=%b exp=1", freeze);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (sram_rd_en !== 1'b1) begin
         failures++;
         $display("FAIL rst_mid_rden got=%b exp=1", sram_rd_en);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({sram_rd_en, freeze} !== 2'b00 || rdata !== 32'd0) begin
         failures++;
         $display("FAIL rst_mid_drop got=%b/%h exp=00/0", {sram_rd_en, freeze}, rdata);
      end
      mem_read = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      expect_read("post_rst1024", 32'd1024, 0, 1, 32'hAAAA_0000);
      expect_read("post_rst1536", 32'd1536, 0, 1, 32'h0BAD_BEEF);
   endtask

   initial begin
      test_reset;
      test_read_miss_hit;
      test_lru;
      test_write;
      test_both_high;
      test_stray_ready;
      test_reset_mid_miss;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
